// File: rtl/gain_pkg.sv
// Shared constants, sample-mode type and saturation-limit helpers for the
// multi-channel gain block.
package gain_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int GAIN_WIDTH_DEF = 16;
  localparam int QUANT_BITS_DEF = 10;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } sat_mode_e;

  // Largest positive two's-complement value representable in `width` bits.
  function automatic logic signed [127:0] sat_max(input int width);
    return (128'sd1 <<< (width - 1)) - 128'sd1;
  endfunction

  function automatic logic signed [127:0] sat_min(input int width);
    return -(128'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/gain_multi_top_fifo.sv
// First-word-fall-through FIFO with registered full/empty flags; writes while
// full and reads while empty are ignored.
module fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_full,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   L_DEPTH   = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   L_ONE     = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] L_PTR_ONE = {{(AW - 1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [AW:0]      w_count_nxt;
  logic             r_full;
  logic             r_empty;
  logic             w_wr;
  logic             w_rd;

  // Qualified handshakes and next occupancy.
  always_comb begin
    w_wr        = i_wr_en & ~r_full;
    w_rd        = i_rd_en & ~r_empty;
    w_count_nxt = r_count;
    if (w_wr && !w_rd) begin
      w_count_nxt = r_count + L_ONE;
    end else if (!w_wr && w_rd) begin
      w_count_nxt = r_count - L_ONE;
    end else begin
      w_count_nxt = r_count;
    end
  end

  // Storage, pointers and flags; storage is cleared so the head reads zero after reset.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= r_wr_ptr + L_PTR_ONE;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == L_DEPTH);
      r_empty <= (w_count_nxt == {(AW + 1){1'b0}});
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_full    = r_full;
  assign o_empty   = r_empty;

endmodule

// File: rtl/gain_multi_top.sv
// Multi-channel fixed-point gain: input FIFO -> ISSUE -> MULT -> SAT -> output
// FIFO, with credit-based issue so the output FIFO can never overflow.
module gain_multi_top
  import gain_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_CH     = 2,
  parameter int GAIN_WIDTH = GAIN_WIDTH_DEF,
  parameter int QUANT_BITS = QUANT_BITS_DEF,
  parameter int FIFO_DEPTH = 16,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_CH*DATA_WIDTH-1:0] din,
  input  logic                         in_wr_en,
  output logic                         in_full,
  output logic [NUM_CH*DATA_WIDTH-1:0] dout,
  input  logic                         out_rd_en,
  output logic                         out_empty,
  input  logic                         gain_wr,
  input  logic [CH_W-1:0]              gain_ch,
  input  logic [GAIN_WIDTH-1:0]        gain_din,
  input  logic                         sat_en
);

  localparam int FW = NUM_CH * DATA_WIDTH;
  localparam int PW = DATA_WIDTH + GAIN_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic signed [PW-1:0]  L_SAT_MAX = PW'(sat_max(DATA_WIDTH));
  localparam logic signed [PW-1:0]  L_SAT_MIN = PW'(sat_min(DATA_WIDTH));
  localparam logic [GAIN_WIDTH-1:0] L_UNITY   = {{(GAIN_WIDTH - 1){1'b0}}, 1'b1} << QUANT_BITS;
  localparam logic [AW:0]           L_DEPTH   = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]           L_ONE     = {{AW{1'b0}}, 1'b1};

  logic [FW-1:0]                  w_in_frame;
  logic                           w_in_empty;
  logic                           w_out_full;
  logic                           w_issue;
  logic                           w_pop;
  logic [FW-1:0]                  w_sat_frame;
  logic signed [PW-1:0]           w_shift [NUM_CH];

  logic signed [GAIN_WIDTH-1:0]   r_gain    [NUM_CH];
  logic signed [DATA_WIDTH-1:0]   r_s1_din  [NUM_CH];
  logic signed [GAIN_WIDTH-1:0]   r_s1_gain [NUM_CH];
  logic signed [PW-1:0]           r_s2_prod [NUM_CH];
  sat_mode_e                      r_s1_sat;
  sat_mode_e                      r_s2_sat;
  logic                           r_v1;
  logic                           r_v2;
  // Output-FIFO entries already promised: stored frames plus frames in the pipeline.
  logic [AW:0]                    r_credit;

  fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_in_fifo (
    .i_clock   (clock),
    .i_reset   (reset),
    .i_wr_en   (in_wr_en),
    .i_wr_data (din),
    .o_full    (in_full),
    .i_rd_en   (w_issue),
    .o_rd_data (w_in_frame),
    .o_empty   (w_in_empty)
  );

  fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_out_fifo (
    .i_clock   (clock),
    .i_reset   (reset),
    .i_wr_en   (r_v2),
    .i_wr_data (w_sat_frame),
    .o_full    (w_out_full),
    .i_rd_en   (out_rd_en),
    .o_rd_data (dout),
    .o_empty   (out_empty)
  );

  assign w_issue = ~w_in_empty & ~w_out_full & (r_credit < L_DEPTH);
  assign w_pop   = out_rd_en & ~out_empty;

  // Credit counter tracking reserved output-FIFO space.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_credit <= '0;
    end else if (w_issue && !w_pop) begin
      r_credit <= r_credit + L_ONE;
    end else if (!w_issue && w_pop) begin
      r_credit <= r_credit - L_ONE;
    end else begin
      r_credit <= r_credit;
    end
  end

  // Per-channel gain registers; out-of-range channel writes are dropped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_gain[c] <= L_UNITY;
      end
    end else if (gain_wr && (int'(gain_ch) < NUM_CH)) begin
      r_gain[gain_ch] <= gain_din;
    end else begin
      r_gain <= r_gain;
    end
  end

  // ISSUE and MULT stages; reset discards any frame in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_s1_sat <= MODE_WRAP;
      r_s2_sat <= MODE_WRAP;
      for (int c = 0; c < NUM_CH; c++) begin
        r_s1_din[c]  <= '0;
        r_s1_gain[c] <= '0;
        r_s2_prod[c] <= '0;
      end
    end else begin
      r_v1     <= w_issue;
      r_v2     <= r_v1;
      r_s2_sat <= r_s1_sat;
      if (w_issue) begin
        r_s1_sat <= sat_mode_e'(sat_en);
        for (int c = 0; c < NUM_CH; c++) begin
          r_s1_din[c]  <= w_in_frame[c*DATA_WIDTH +: DATA_WIDTH];
          r_s1_gain[c] <= r_gain[c];
        end
      end
      for (int c = 0; c < NUM_CH; c++) begin
        r_s2_prod[c] <= PW'(r_s1_din[c]) * PW'(r_s1_gain[c]);
      end
    end
  end

  // SAT stage: arithmetic shift out the fraction, then clamp or wrap.
  always_comb begin
    w_sat_frame = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_shift[c] = r_s2_prod[c] >>> QUANT_BITS;
      if ((r_s2_sat == MODE_SAT) && (w_shift[c] > L_SAT_MAX)) begin
        w_sat_frame[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(L_SAT_MAX);
      end else if ((r_s2_sat == MODE_SAT) && (w_shift[c] < L_SAT_MIN)) begin
        w_sat_frame[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(L_SAT_MIN);
      end else begin
        w_sat_frame[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(w_shift[c]);
      end
    end
  end

endmodule

// File: tb/tb_gain_multi_top.sv
// Self-checking bench for gain_multi_top: directed vector table, latency and
// reset sequences, plus randomized traffic against a queue-based reference.
module tb_gain_multi_top;

  localparam int DEPTH = 16;
  localparam int QB    = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] din = 64'h0;
  logic        in_wr_en = 1'b0;
  logic        in_full;
  logic [63:0] dout;
  logic        out_rd_en = 1'b0;
  logic        out_empty;
  logic        gain_wr = 1'b0;
  logic [0:0]  gain_ch = 1'b0;
  logic [15:0] gain_din = 16'h0;
  logic        sat_en = 1'b1;

  always #5 clock = ~clock;

  gain_multi_top dut (
    .clock(clock), .reset(reset), .din(din), .in_wr_en(in_wr_en), .in_full(in_full),
    .dout(dout), .out_rd_en(out_rd_en), .out_empty(out_empty), .gain_wr(gain_wr),
    .gain_ch(gain_ch), .gain_din(gain_din), .sat_en(sat_en)
  );

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    logic [15:0] g0;
    logic [15:0] g1;
    logic        sat;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t        vecs[7];
  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] sb_q[$];
  logic [15:0] mg[2];
  logic        msat;
  bit          sb_on;

  // Reference: full signed product, arithmetic shift, optional clamp to 32 bits.
  function automatic logic [31:0] ref_ch(input logic [31:0] d, input logic [15:0] g, input logic sat);
    longint p;
    longint s;
    p = longint'(signed'(d)) * longint'(signed'(g));
    s = p >>> QB;
    if (sat && s > 64'sd2147483647) return 32'h7FFF_FFFF;
    else if (sat && s < -64'sd2147483648) return 32'h8000_0000;
    else return s[31:0];
  endfunction

  function automatic logic [63:0] ref_frame(input logic [63:0] d);
    return {ref_ch(d[63:32], mg[1], msat), ref_ch(d[31:0], mg[0], msat)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // One clock: drive inputs, score the pop/push seen at the coming edge.
  task automatic step(input logic wr, input logic [63:0] d, input logic rd);
    logic [63:0] e;
    in_wr_en  = wr;
    din       = d;
    out_rd_en = rd;
    if (sb_on && rd && !out_empty) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_extra: got %h required no frame", dout);
      end else begin
        e = sb_q.pop_front();
        chk("sb_frame", dout, e);
      end
    end
    if (sb_on && wr && !in_full) sb_q.push_back(ref_frame(d));
    @(posedge clock);
    #1;
    in_wr_en  = 1'b0;
    out_rd_en = 1'b0;
  endtask

  task automatic set_gain(input logic ch, input logic [15:0] g);
    gain_ch  = ch;
    gain_din = g;
    gain_wr  = 1'b1;
    @(posedge clock);
    #1;
    gain_wr  = 1'b0;
    mg[ch]   = g;
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && sb_q.size() != 0; i++) step(1'b0, 64'h0, 1'b1);
    chk("drain_left", 64'(sb_q.size()), 64'd0);
  endtask

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 5))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h0000_1234, 32'hFFFF_EDCC, 16'h0400, 16'h0400, 1'b1, 32'h0000_1234, 32'hFFFF_EDCC};
    vecs[1] = '{32'h4000_0000, 32'hC000_0000, 16'h0800, 16'h0800, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000};
    vecs[2] = '{32'h4000_0000, 32'hC000_0000, 16'h0800, 16'h0800, 1'b0, 32'h8000_0000, 32'h8000_0000};
    vecs[3] = '{32'h0000_0100, 32'h0000_0100, 16'h0200, 16'h0400, 1'b1, 32'h0000_0080, 32'h0000_0100};
    vecs[4] = '{32'h8000_0000, 32'h0000_0005, 16'hFC00, 16'hFC00, 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFB};
    vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0400, 16'h0001, 16'h0001, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[6] = '{32'h8000_0000, 32'h7FFF_FFFF, 16'hFC00, 16'h0400, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF};
    mg[0] = 16'h0400;
    mg[1] = 16'h0400;
    msat  = 1'b1;
    sb_on = 1'b0;

    #12;
    chk("rst_out_empty", 64'(out_empty), 64'd1);
    chk("rst_in_full", 64'(in_full), 64'd0);
    chk("rst_dout", dout, 64'h0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Directed table with 3-cycle latency check per vector.
    for (int i = 0; i < 7; i++) begin
      set_gain(1'b0, vecs[i].g0);
      set_gain(1'b1, vecs[i].g1);
      sat_en = vecs[i].sat;
      step(1'b1, {vecs[i].d1, vecs[i].d0}, 1'b0);
      for (int k = 1; k <= 3; k++) begin
        step(1'b0, 64'h0, 1'b0);
        chk($sformatf("vec%0d_lat%0d", i, k), 64'(out_empty), 64'(k < 3));
      end
      chk($sformatf("vec%0d_dout", i), dout, {vecs[i].e1, vecs[i].e0});
      step(1'b0, 64'h0, 1'b1);
      chk($sformatf("vec%0d_empty", i), 64'(out_empty), 64'd1);
    end

    // Unity-gain stream of 100 frames at full rate.
    sb_on = 1'b1;
    set_gain(1'b0, 16'h0400);
    set_gain(1'b1, 16'h0400);
    sat_en = 1'b1;
    msat   = 1'b1;
    for (int j = 0; j < 100; j++) begin
      step(1'b1, 64'hFFFF_EDCC_0000_1234, 1'b1);
      if (j < 4) chk($sformatf("stream_lat%0d", j), 64'(out_empty), 64'(j < 3));
    end
    drain(50);

    // Back-pressure: overfill with no reads, then drain in order.
    for (int j = 0; j < 2 * DEPTH + 3; j++) step(1'b1, {rnd_word(), rnd_word()}, 1'b0);
    for (int j = 0; j < 5; j++) step(1'b0, 64'h0, 1'b0);
    chk("bp_in_full", 64'(in_full), 64'd1);
    chk("bp_out_nonempty", 64'(out_empty), 64'd0);
    drain(200);

    // Gain change between frame 5 and frame 6.
    for (int j = 0; j < 6; j++) step(1'b1, {rnd_word(), rnd_word()}, 1'b0);
    for (int j = 0; j < 3; j++) step(1'b0, 64'h0, 1'b0);
    set_gain(1'b0, 16'h0300);
    set_gain(1'b1, 16'hFE00);
    for (int j = 0; j < 6; j++) step(1'b1, {rnd_word(), rnd_word()}, 1'b0);
    drain(60);

    // Randomized batches; gains and mode change only while the pipe is empty.
    for (int b = 0; b < 3; b++) begin
      set_gain(1'b0, 16'($urandom_range(0, 65535)));
      set_gain(1'b1, 16'($urandom_range(0, 65535)));
      msat   = 1'($urandom_range(0, 1));
      sat_en = msat;
      for (int j = 0; j < 200; j++)
        step(1'($urandom_range(0, 3) != 0), {rnd_word(), rnd_word()}, 1'($urandom_range(0, 2) != 0));
      drain(400);
    end

    // Reset with frames in flight, then unity-gain traffic.
    set_gain(1'b0, 16'h0800);
    set_gain(1'b1, 16'h0800);
    for (int j = 0; j < 5; j++) step(1'b1, {rnd_word(), rnd_word()}, 1'b0);
    chk("pre_rst_nonempty", 64'(out_empty), 64'd0);
    reset = 1'b0;
    #1;
    chk("mid_rst_out_empty", 64'(out_empty), 64'd1);
    chk("mid_rst_in_full", 64'(in_full), 64'd0);
    chk("mid_rst_dout", dout, 64'h0);
    sb_q.delete();
    mg[0] = 16'h0400;
    mg[1] = 16'h0400;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int j = 0; j < 10; j++) step(1'b1, {rnd_word(), rnd_word()}, 1'b1);
    drain(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
